coin_input_conditioner: RTL and testbench

- Upstream stage of the vending-machine controller FSM.
- Takes two raw, bouncy, asynchronous coin-sensor lines (0.5-unit and 1-unit slots) and cleans them up.
- Emits one-cycle, mutually exclusive coin pulses on a 2-bit bus. Encoding: bit0 = 0.5 unit, bit1 = 1 unit.
- Guarantees a minimum idle gap between pulses, so the downstream FSM sees every coin exactly once, including across its dispense states.

---
 rtl/coin_input_conditioner.sv | 163 ++++++++++++++++
 tb/tb_coin_input_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// Coin sensor front end: 2-flop sync, per-channel debounce, pending flags and a gap-enforcing pulse scheduler.
// Optional audit counters (cnt_half, cnt_one, cnt_drop) are built only when COIN_AUDIT_CNT_EN is defined.
module coin_input_conditioner #(
    parameter int DEB_CYCLES = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_half,
    input  logic       raw_one,
    output logic [1:0] coin,
    output logic       drop
`ifdef COIN_AUDIT_CNT_EN
    ,
    output logic [7:0] cnt_half,
    output logic [7:0] cnt_one,
    output logic [7:0] cnt_drop
`endif
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } state_t;

    // Channel index 0 is the 0.5-unit slot, index 1 the 1-unit slot, matching the coin bit order.
    logic [1:0] raw_vec;
    logic [1:0] pend;
    logic [1:0] rise_evt;
    logic [1:0] drop_evt;
    logic [1:0] clr;

    assign raw_vec = {raw_one, raw_half};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_ch
            logic       sync1_reg;
            logic       sync2_reg;
            logic       deb_reg;
            logic       deb_d_reg;
            logic       pend_reg;
            logic [7:0] cnt_reg;

            assign rise_evt[gi] = deb_reg & ~deb_d_reg;
            assign pend[gi]     = pend_reg;
            // A clear coinciding with a new event keeps the flag set, so that event is not lost.
            assign drop_evt[gi] = rise_evt[gi] & pend_reg & ~clr[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    pend_reg  <= 1'b0;
                    cnt_reg   <= 8'd0;
                end else begin
                    sync1_reg <= raw_vec[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= 8'd0;
                    end else if (cnt_reg == DEB_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                    if (rise_evt[gi]) begin
                        pend_reg <= 1'b1;
                    end else if (clr[gi]) begin
                        pend_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    state_t     state_reg, state_next;
    logic [1:0] sel_reg, sel_next;
    logic [7:0] gap_reg, gap_next;
    logic [1:0] coin_reg, coin_next;
    logic       drop_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            sel_reg   <= 2'b00;
            gap_reg   <= 8'd0;
            coin_reg  <= 2'b00;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            gap_reg   <= gap_next;
            coin_reg  <= coin_next;
            drop_reg  <= |drop_evt;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        gap_next   = gap_reg;
        coin_next  = 2'b00;
        clr        = 2'b00;
        case (state_reg)
            S_IDLE: begin
                if (pend[0]) begin
                    clr[0]     = 1'b1;
                    sel_next   = 2'b01;
                    state_next = S_PULSE;
                end else if (pend[1]) begin
                    clr[1]     = 1'b1;
                    sel_next   = 2'b10;
                    state_next = S_PULSE;
                end
            end
            S_PULSE: begin
                coin_next  = sel_reg;
                gap_next   = GAP_LOAD;
                state_next = S_GAP;
            end
            S_GAP: begin
                // Leave once the decremented count lands on 1 (or below, for a gap of 1).
                gap_next = gap_reg - 8'd1;
                if (gap_reg <= 8'd2) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign coin = coin_reg;
    assign drop = drop_reg;

`ifdef COIN_AUDIT_CNT_EN
    logic [7:0] cnt_half_reg, cnt_one_reg, cnt_drop_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_half_reg <= 8'd0;
            cnt_one_reg  <= 8'd0;
            cnt_drop_reg <= 8'd0;
        end else begin
            if (coin_next == 2'b01 && cnt_half_reg != 8'hFF) cnt_half_reg <= cnt_half_reg + 8'd1;
            if (coin_next == 2'b10 && cnt_one_reg != 8'hFF)  cnt_one_reg  <= cnt_one_reg + 8'd1;
            if ((|drop_evt) && cnt_drop_reg != 8'hFF)        cnt_drop_reg <= cnt_drop_reg + 8'd1;
        end
    end

    assign cnt_half = cnt_half_reg;
    assign cnt_one  = cnt_one_reg;
    assign cnt_drop = cnt_drop_reg;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: table of per-cycle raw patterns with expected pulse counts/times,
// plus hand-written reset-in-gap and (with COIN_AUDIT_CNT_EN) counter saturation sequences.
module tb_coin_input_conditioner;

    localparam int W = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw_half = 1'b0;
    logic       raw_one = 1'b0;
    logic [1:0] coin4, coin1;
    logic       drop4, drop1;
`ifdef COIN_AUDIT_CNT_EN
    logic [7:0] ch4, co4, cd4, ch1, co1, cd1;
`endif

    always #5 clk = ~clk;

    // u4: DEB=4/GAP=2 for the main cases; u1: DEB=1/GAP=2 so coins can re-arrive within one gap.
    coin_input_conditioner #(.DEB_CYCLES(4), .GAP_CYCLES(2)) u4 (
        .clk(clk), .rst(rst), .raw_half(raw_half), .raw_one(raw_one),
        .coin(coin4), .drop(drop4)
`ifdef COIN_AUDIT_CNT_EN
        , .cnt_half(ch4), .cnt_one(co4), .cnt_drop(cd4)
`endif
    );

    coin_input_conditioner #(.DEB_CYCLES(1), .GAP_CYCLES(2)) u1 (
        .clk(clk), .rst(rst), .raw_half(raw_half), .raw_one(raw_one),
        .coin(coin1), .drop(drop1)
`ifdef COIN_AUDIT_CNT_EN
        , .cnt_half(ch1), .cnt_one(co1), .cnt_drop(cd1)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          sel;       // 0 -> u4, 1 -> u1
        logic [39:0] half_pat;  // bit i = raw_half before edge i
        logic [39:0] one_pat;
        int n01, f01, l01;      // count, first and last edge of 01 pulses (-1 = none)
        int n10, f10, l10;
        int nd, fd;             // drop count and first drop edge
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n01 = 0, n10 = 0, nd = 0, ill = 0;
        int f01 = -1, l01 = -1, f10 = -1, l10 = -1, fd = -1;
        logic [1:0] c;
        logic d;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            if (i > 0) begin
                c = (v.sel == 1) ? coin1 : coin4;
                d = (v.sel == 1) ? drop1 : drop4;
                if (c == 2'b01) begin n01++; if (f01 < 0) f01 = i - 1; l01 = i - 1; end
                if (c == 2'b10) begin n10++; if (f10 < 0) f10 = i - 1; l10 = i - 1; end
                if (c == 2'b11) ill++;
                if (d) begin nd++; if (fd < 0) fd = i - 1; end
            end
            if (i < W) begin
                raw_half = v.half_pat[i];
                raw_one  = v.one_pat[i];
            end else begin
                raw_half = 1'b0;
                raw_one  = 1'b0;
            end
        end
        repeat (10) @(negedge clk);
        check($sformatf("v%0d_n01", idx), n01, v.n01);
        check($sformatf("v%0d_f01", idx), f01, v.f01);
        check($sformatf("v%0d_l01", idx), l01, v.l01);
        check($sformatf("v%0d_n10", idx), n10, v.n10);
        check($sformatf("v%0d_f10", idx), f10, v.f10);
        check($sformatf("v%0d_l10", idx), l10, v.l10);
        check($sformatf("v%0d_ndrop", idx), nd, v.nd);
        check($sformatf("v%0d_fdrop", idx), fd, v.fd);
        check($sformatf("v%0d_coin11", idx), ill, 0);
        $display("vec %0d sel=%0d: 01 x%0d @%0d..%0d, 10 x%0d @%0d..%0d, drop x%0d @%0d",
                 idx, v.sel, n01, f01, l01, n10, f10, l10, nd, fd);
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{0, 40'hF_FFFF,       40'h0,          1, 8, 8,   0, -1, -1,  0, -1};
        vecs[1]  = '{0, 40'h0,            40'hF_FFFF,     0, -1, -1, 1, 8, 8,    0, -1};
        vecs[2]  = '{0, 40'hF_FFFF,       40'hF_FFFF,     1, 8, 8,   1, 11, 11,  0, -1};
        vecs[3]  = '{0, 40'h0,            40'h56DB56DB55, 0, -1, -1, 0, -1, -1,  0, -1};
        vecs[4]  = '{0, 40'h7,            40'h0,          0, -1, -1, 0, -1, -1,  0, -1};
        vecs[5]  = '{0, 40'hF,            40'h0,          1, 8, 8,   0, -1, -1,  0, -1};
        vecs[6]  = '{0, 40'hFF_FFFF_FFFF, 40'h0,          1, 8, 8,   0, -1, -1,  0, -1};
        vecs[7]  = '{0, 40'h3_F03F,       40'h0,          2, 8, 20,  0, -1, -1,  0, -1};
        vecs[8]  = '{0, 40'h3F_FFFC,      40'hF_FFFF,     1, 11, 11, 1, 8, 8,    0, -1};
        vecs[9]  = '{1, 40'h7FA,          40'h7FD,        1, 8, 8,   2, 5, 11,   1, 6};
        vecs[10] = '{1, 40'h1,            40'h0,          1, 5, 5,   0, -1, -1,  0, -1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_coin_u4", int'(coin4), 0);
        check("reset_drop_u4", int'(drop4), 0);
        check("reset_coin_u1", int'(coin1), 0);
        check("reset_drop_u1", int'(drop1), 0);
        $display("reset: coin4=%0d drop4=%0d coin1=%0d drop1=%0d", coin4, drop4, coin1, drop1);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 11; k++) run_vec(k, vecs[k]);

        // Reset mid-pulse/mid-gap while a 1-unit coin is still pending.
        @(negedge clk);
        raw_half = 1'b1;
        raw_one  = 1'b1;
        repeat (9) @(posedge clk);
        #2;
        check("gaprst_pre_u4", int'(coin4), 1);
        check("gaprst_pre_u1", int'(coin1), 2);
        rst = 1'b1;
        raw_half = 1'b0;
        raw_one  = 1'b0;
        #1;
        check("gaprst_coin_u4", int'(coin4), 0);
        check("gaprst_drop_u4", int'(drop4), 0);
        check("gaprst_coin_u1", int'(coin1), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (coin4 != 2'b00) pulses++;
            if (coin1 != 2'b00) pulses++;
        end
        check("gaprst_no_pulse_after", pulses, 0);
        $display("reset in gap: pulses after release=%0d", pulses);

`ifdef COIN_AUDIT_CNT_EN
        check("audit_rst_half_u1", int'(ch1), 0);
        check("audit_rst_one_u4", int'(co4), 0);
        for (int c = 0; c < 10; c++) begin
            for (int s = 0; s < 6; s++) begin
                @(negedge clk);
                raw_half = (s < 3);
            end
        end
        raw_half = 1'b0;
        repeat (10) @(negedge clk);
        check("audit_half_10", int'(ch1), 10);
        $display("audit: after 10 coins cnt_half=%0d", ch1);
        for (int c = 0; c < 290; c++) begin
            for (int s = 0; s < 6; s++) begin
                @(negedge clk);
                raw_half = (s < 3);
            end
        end
        raw_half = 1'b0;
        repeat (10) @(negedge clk);
        check("audit_half_sat", int'(ch1), 255);
        check("audit_one_zero", int'(co1), 0);
        check("audit_drop_zero", int'(cd1), 0);
        check("audit_u4_glitch_half", int'(ch4), 0);
        $display("audit: after 300 coins cnt_half=%0d cnt_one=%0d cnt_drop=%0d", ch1, co1, cd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
